// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width,
// counter widths and the default acceptance timeout.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam int BYTE_W          = 8;
    localparam int GRANT_W         = 3;
    localparam int CNT_W           = 12;
    localparam int DEFAULT_TIMEOUT = 4095;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART transmit arbiter.
// The master view belongs to the arbiter; the slave view is the surrounding
// requesters plus the transmitter.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        i_Req;
    logic [BYTE_W*NUM_REQ-1:0] i_Req_Data;
    logic [NUM_REQ-1:0]        o_Ack;
    logic                      o_Wr_En;
    logic [BYTE_W-1:0]         o_Data_Out;
    logic                      i_Tx_Ready;

    modport master (
        input  i_Req,
        input  i_Req_Data,
        input  i_Tx_Ready,
        output o_Ack,
        output o_Wr_En,
        output o_Data_Out
    );

    modport slave (
        output i_Req,
        output i_Req_Data,
        output i_Tx_Ready,
        input  o_Ack,
        input  o_Wr_En,
        input  o_Data_Out
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector. The search begins one past the
// last served requester and wraps, so the winner is the requesting index with
// the smallest forward distance from i_Last_Grant.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [GRANT_W-1:0] i_Last_Grant,
    output logic [NUM_REQ-1:0] o_Grant,
    output logic [GRANT_W-1:0] o_Grant_Id,
    output logic               o_Valid
);

    int w_Dist;
    int w_Best_Dist;
    int w_Pick;

    assign o_Valid    = |i_Req;
    assign o_Grant_Id = GRANT_W'(w_Pick);

    // Find the requester closest (going forward) to the one after the last grant.
    always_comb begin
        w_Best_Dist = NUM_REQ;
        w_Pick      = 0;
        w_Dist      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_Dist = (k + NUM_REQ - 1 - int'(i_Last_Grant)) % NUM_REQ;
            if (i_Req[k] && (w_Dist < w_Best_Dist)) begin
                w_Best_Dist = w_Dist;
                w_Pick      = k;
            end
        end
    end

    // Expand the chosen index into a one-hot grant, zero when nobody requests.
    always_comb begin
        o_Grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_Grant[k] = o_Valid && (k == w_Pick);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters. A byte is chosen
// round-robin in IDLE, written with o_Wr_En during LOAD until the transmitter
// drops ready, and the FSM then waits in WAIT_DONE for ready to return.
// Reset asserts asynchronously and releases through a two-flop synchronizer.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               i_Clk_12MHz,
    input  logic               i_Reset_N,
    uart_tx_arbiter_if.master  bus,
    output logic [GRANT_W-1:0] o_Grant_Id,
    output logic               o_Busy,
    output logic               o_Timeout_Err
);

    // LOAD gives up once the counter has seen TIMEOUT write cycles, so the
    // comparison is against the value held in the last allowed cycle.
    localparam logic [CNT_W-1:0]   C_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] C_LAST_RESET   = GRANT_W'(NUM_REQ - 1);

    logic [1:0]         r_Rst_Sync;
    logic               w_Rst_N;
    logic [1:0]         r_Ready_Sync;
    logic               w_Ready;

    state_t             r_State;
    state_t             w_Next_State;
    logic [BYTE_W-1:0]  r_Data_Out;
    logic [BYTE_W-1:0]  w_Next_Data;
    logic [GRANT_W-1:0] r_Grant_Id;
    logic [GRANT_W-1:0] w_Next_Grant_Id;
    logic [NUM_REQ-1:0] r_Ack;
    logic [NUM_REQ-1:0] w_Next_Ack;
    logic [CNT_W-1:0]   r_Count;
    logic [CNT_W-1:0]   w_Next_Count;
    logic [GRANT_W-1:0] r_Last_Grant;
    logic [GRANT_W-1:0] w_Next_Last;
    logic               r_Timeout_Err;
    logic               w_Next_Err;

    logic [NUM_REQ-1:0] w_Arb_Grant;
    logic [GRANT_W-1:0] w_Arb_Id;
    logic               w_Arb_Valid;
    logic [BYTE_W-1:0]  w_Sel_Byte;

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge i_Clk_12MHz or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_Rst_Sync <= 2'b00;
        end else begin
            r_Rst_Sync <= {r_Rst_Sync[0], 1'b1};
        end
    end

    assign w_Rst_N = r_Rst_Sync[1];

    // Bring the baud-domain ready into this clock domain; idles as ready.
    always_ff @(posedge i_Clk_12MHz or negedge w_Rst_N) begin
        if (!w_Rst_N) begin
            r_Ready_Sync <= 2'b11;
        end else begin
            r_Ready_Sync <= {r_Ready_Sync[0], bus.i_Tx_Ready};
        end
    end

    assign w_Ready = r_Ready_Sync[1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_Req        (bus.i_Req),
        .i_Last_Grant (r_Last_Grant),
        .o_Grant      (w_Arb_Grant),
        .o_Grant_Id   (w_Arb_Id),
        .o_Valid      (w_Arb_Valid)
    );

    // Pick the winning requester's byte out of the packed data bus.
    always_comb begin
        w_Sel_Byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_Arb_Grant[k]) begin
                w_Sel_Byte = bus.i_Req_Data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and next-datapath logic; everything holds unless changed.
    always_comb begin
        w_Next_State    = r_State;
        w_Next_Data     = r_Data_Out;
        w_Next_Grant_Id = r_Grant_Id;
        w_Next_Ack      = '0;
        w_Next_Count    = r_Count;
        w_Next_Last     = r_Last_Grant;
        w_Next_Err      = r_Timeout_Err;
        case (r_State)
            ST_IDLE: begin
                if (w_Arb_Valid && w_Ready) begin
                    w_Next_State    = ST_LOAD;
                    w_Next_Data     = w_Sel_Byte;
                    w_Next_Grant_Id = w_Arb_Id;
                    w_Next_Ack      = w_Arb_Grant;
                    w_Next_Count    = '0;
                end
            end
            ST_LOAD: begin
                w_Next_Count = r_Count + 1'b1;
                if (!w_Ready) begin
                    w_Next_State = ST_WAIT_DONE;
                end else if (r_Count == C_TIMEOUT_LAST) begin
                    w_Next_State = ST_IDLE;
                    w_Next_Err   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (w_Ready) begin
                    w_Next_State = ST_IDLE;
                    w_Next_Last  = r_Grant_Id;
                end
            end
            default: begin
                w_Next_State = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_Clk_12MHz or negedge w_Rst_N) begin
        if (!w_Rst_N) begin
            r_State       <= ST_IDLE;
            r_Data_Out    <= '0;
            r_Grant_Id    <= '0;
            r_Ack         <= '0;
            r_Count       <= '0;
            r_Last_Grant  <= C_LAST_RESET;
            r_Timeout_Err <= 1'b0;
        end else begin
            r_State       <= w_Next_State;
            r_Data_Out    <= w_Next_Data;
            r_Grant_Id    <= w_Next_Grant_Id;
            r_Ack         <= w_Next_Ack;
            r_Count       <= w_Next_Count;
            r_Last_Grant  <= w_Next_Last;
            r_Timeout_Err <= w_Next_Err;
        end
    end

    assign bus.o_Wr_En    = (r_State == ST_LOAD);
    assign bus.o_Ack      = r_Ack;
    assign bus.o_Data_Out = r_Data_Out;
    assign o_Grant_Id     = r_Grant_Id;
    assign o_Busy         = (r_State != ST_IDLE);
    assign o_Timeout_Err  = r_Timeout_Err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small serializing transmitter model.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [2:0] grantId;
    logic       busy;
    logic       timeoutErr;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_Clk_12MHz   (clk),
        .i_Reset_N     (resetN),
        .bus           (bus),
        .o_Grant_Id    (grantId),
        .o_Busy        (busy),
        .o_Timeout_Err (timeoutErr)
    );

    always #5 clk = ~clk;

    // Transmitter model: takes a byte on a write while ready, then holds ready
    // low while it shifts out a 10-bit frame (start, 8 data LSB first, stop).
    logic       txModelEn = 1'b1;
    logic       txHoldLow = 1'b0;
    logic       txModelReady = 1'b1;
    logic [9:0] txShift = '0;
    logic [9:0] rxFrame = '0;
    logic [7:0] txCaptured = '0;
    int         txBitsLeft = 0;
    int         txCaptures = 0;

    assign bus.i_Tx_Ready = txHoldLow ? 1'b0 : txModelReady;

    always @(posedge clk) begin
        if (txModelEn && bus.o_Wr_En && txModelReady) begin
            txShift      <= {1'b1, bus.o_Data_Out, 1'b0};
            txCaptured   <= bus.o_Data_Out;
            txCaptures   <= txCaptures + 1;
            txBitsLeft   <= 10;
            txModelReady <= 1'b0;
        end else if (txBitsLeft != 0) begin
            rxFrame    <= {txShift[0], rxFrame[9:1]};
            txShift    <= {1'b0, txShift[9:1]};
            txBitsLeft <= txBitsLeft - 1;
            if (txBitsLeft == 1) txModelReady <= 1'b1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         ackPulses = 0;
    int         wrEnCycles = 0;
    logic [3:0] ackSeen = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearCounters();
        ackPulses  = 0;
        wrEnCycles = 0;
        ackSeen    = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (|bus.o_Ack) ackPulses++;
        ackSeen = ackSeen | bus.o_Ack;
        if (bus.o_Wr_En) wrEnCycles++;
    endtask

    task automatic applyStimulus(input logic [3:0] req);
        bus.i_Req = req;
    endtask

    task automatic waitAck(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (|bus.o_Ack) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, " ack seen"}, 32'(found), 32'd1);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, " idle reached"}, 32'(found), 32'd1);
    endtask

    int expOrder[5] = '{0, 1, 2, 3, 0};

    initial begin
        logic found;
        bus.i_Req      = '0;
        bus.i_Req_Data = '0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset wr_en",   32'(bus.o_Wr_En),    32'd0);
        checkOutput("reset ack",     32'(bus.o_Ack),      32'd0);
        checkOutput("reset data",    32'(bus.o_Data_Out), 32'd0);
        checkOutput("reset grant",   32'(grantId),        32'd0);
        checkOutput("reset busy",    32'(busy),           32'd0);
        checkOutput("reset timeout", 32'(timeoutErr),     32'd0);
        resetN = 1'b1;
        repeat (4) tick();

        // Fairness: all four held high, order 0,1,2,3,0
        $display("[TB] fairness");
        bus.i_Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
        clearCounters();
        applyStimulus(4'b1111);
        for (int n = 0; n < 5; n++) begin
            waitAck($sformatf("fair %0d", n), 60);
            checkOutput($sformatf("fair %0d grant", n), 32'(grantId), 32'(expOrder[n]));
            checkOutput($sformatf("fair %0d ack", n), 32'(bus.o_Ack), 32'(1 << expOrder[n]));
            checkOutput($sformatf("fair %0d data", n), 32'(bus.o_Data_Out), 32'(8'h10 + expOrder[n]));
        end
        applyStimulus(4'b0000);
        waitIdle("fair", 60);
        checkOutput("fair ack pulses", 32'(ackPulses), 32'd5);

        // Single request from requester 2 with byte A5
        $display("[TB] single request");
        bus.i_Req_Data = {8'h00, 8'hA5, 8'h00, 8'h00};
        clearCounters();
        found = 1'b0;
        applyStimulus(4'b0100);
        waitAck("single", 10);
        checkOutput("single ack",   32'(bus.o_Ack),      32'h4);
        checkOutput("single grant", 32'(grantId),        32'd2);
        checkOutput("single data",  32'(bus.o_Data_Out), 32'hA5);
        checkOutput("single wr_en", 32'(bus.o_Wr_En),    32'd1);
        applyStimulus(4'b0000);
        waitIdle("single", 40);
        checkOutput("single ack pulses", 32'(ackPulses),  32'd1);
        checkOutput("single wr_en len",  32'(wrEnCycles), 32'd4);
        checkOutput("single tx byte",    32'(txCaptured), 32'hA5);
        checkOutput("single tx frame",   32'(rxFrame),    32'h34A);

        // Ready low at grant time: nothing until ready returns
        $display("[TB] ready low");
        bus.i_Req_Data = {8'hC3, 8'h00, 8'h00, 8'h00};
        txHoldLow = 1'b1;
        repeat (3) tick();
        clearCounters();
        applyStimulus(4'b1000);
        repeat (10) tick();
        checkOutput("rdylow no ack",  32'(ackPulses), 32'd0);
        checkOutput("rdylow no busy", 32'(busy),      32'd0);
        txHoldLow = 1'b0;
        waitAck("rdylow", 10);
        checkOutput("rdylow ack",   32'(bus.o_Ack),      32'h8);
        checkOutput("rdylow grant", 32'(grantId),        32'd3);
        checkOutput("rdylow data",  32'(bus.o_Data_Out), 32'hC3);
        applyStimulus(4'b0000);
        waitIdle("rdylow", 40);

        // Request 1 pulses for one cycle while busy: never acked
        $display("[TB] drop before grant");
        bus.i_Req_Data = {8'h00, 8'h00, 8'h99, 8'h3C};
        clearCounters();
        applyStimulus(4'b0001);
        waitAck("drop", 10);
        checkOutput("drop grant", 32'(grantId), 32'd0);
        applyStimulus(4'b0010);
        tick();
        checkOutput("drop busy during pulse", 32'(busy), 32'd1);
        applyStimulus(4'b0000);
        waitIdle("drop", 40);
        repeat (10) tick();
        checkOutput("drop acks", 32'(ackSeen), 32'h1);

        // Timeout: transmitter never drops ready
        $display("[TB] timeout");
        txModelEn = 1'b0;
        checkOutput("timeout flag before", 32'(timeoutErr), 32'd0);
        clearCounters();
        applyStimulus(4'b0001);
        waitAck("timeout", 10);
        applyStimulus(4'b0000);
        waitIdle("timeout", 40);
        checkOutput("timeout wr_en len", 32'(wrEnCycles), 32'd16);
        checkOutput("timeout flag",      32'(timeoutErr), 32'd1);
        checkOutput("timeout busy",      32'(busy),       32'd0);
        repeat (5) tick();
        checkOutput("timeout sticky",    32'(timeoutErr), 32'd1);
        checkOutput("timeout ack pulses", 32'(ackPulses), 32'd1);

        // Reset during WAIT_DONE, then requester 1 served normally
        $display("[TB] reset mid-transfer");
        txModelEn = 1'b1;
        bus.i_Req_Data = {8'h00, 8'h77, 8'h5C, 8'h00};
        clearCounters();
        applyStimulus(4'b0100);
        waitAck("midrst", 10);
        checkOutput("midrst first grant", 32'(grantId), 32'd2);
        applyStimulus(4'b0000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy && !bus.o_Wr_En) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midrst wait_done reached", 32'(found), 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("midrst wr_en",   32'(bus.o_Wr_En),    32'd0);
        checkOutput("midrst ack",     32'(bus.o_Ack),      32'd0);
        checkOutput("midrst data",    32'(bus.o_Data_Out), 32'd0);
        checkOutput("midrst grant",   32'(grantId),        32'd0);
        checkOutput("midrst busy",    32'(busy),           32'd0);
        checkOutput("midrst timeout", 32'(timeoutErr),     32'd0);
        repeat (2) tick();
        resetN = 1'b1;
        applyStimulus(4'b0010);
        waitAck("midrst after", 60);
        checkOutput("midrst after ack",   32'(bus.o_Ack),      32'h2);
        checkOutput("midrst after grant", 32'(grantId),        32'd1);
        checkOutput("midrst after data",  32'(bus.o_Data_Out), 32'h5C);
        applyStimulus(4'b0000);
        waitIdle("midrst after", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 4095, max i_Clk_12MHz cycles to wait for transmitter acceptance.
REQ-003 i_Clk_12MHz  in  1  sole clock; every flop on its rising edge.
REQ-004 i_Reset_N  in  1  asynchronous, active-low reset.
REQ-005 i_Req  in  NUM_REQ  per-requester level request; held high until acked.
REQ-006 i_Req_Data  in  8*NUM_REQ  request byte; requester k occupies bits [8k+7:8k].
REQ-007 o_Ack  out  NUM_REQ  one-cycle pulse: requester k's byte captured, requester may drop or change request.
REQ-008 o_Wr_En  out  1  write strobe to transmitter.
REQ-009 o_Data_Out  out  8  byte to transmitter, stable while o_Wr_En high.
REQ-010 i_Tx_Ready  in  1  transmitter ready, generated on the divided baud clock; treated as asynchronous.
REQ-011 o_Grant_Id  out  3  index of requester currently being served.
REQ-012 o_Busy  out  1  high in any state other than IDLE.
REQ-013 o_Timeout_Err  out  1  sticky error flag.

Function
REQ-014 i_Tx_Ready SHALL pass a 2-flop synchronizer (reset value 1) before use; "ready" below means the synchronized value.
REQ-015 FSM states: IDLE, LOAD, WAIT_DONE.
REQ-016 IDLE: if any i_Req bit is high and ready=1, select by round-robin, latch that byte into o_Data_Out, set o_Grant_Id, pulse o_Ack[k] in the next cycle, go to LOAD.
REQ-017 Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-018 IDLE with ready=0: no grant, no ack; wait.
REQ-019 LOAD: o_Wr_En=1 and a 12-bit wait counter increments each cycle.
REQ-020 LOAD exits to WAIT_DONE on the first cycle ready=0; o_Wr_En falls on that transition.
REQ-021 LOAD: if the counter reaches TIMEOUT before ready=0, set o_Timeout_Err, drop o_Wr_En, return to IDLE. The byte is lost and not re-requested.
REQ-022 WAIT_DONE: o_Wr_En=0; on ready=1, update last_grant to o_Grant_Id and go to IDLE.
REQ-023 Exactly one o_Ack pulse per accepted byte; o_Ack is one-hot or zero.
REQ-024 Requests arriving or dropping outside IDLE SHALL be ignored until the next IDLE evaluation.
REQ-025 A request dropped before grant SHALL produce no ack.
REQ-026 Minimum IDLE-to-IDLE cycle: 1 IDLE + LOAD until ready falls + WAIT_DONE; no back-to-back grant without returning to IDLE.
REQ-027 o_Timeout_Err clears only on reset.

Reset
REQ-028 Asserting i_Reset_N low, at any time including mid-transfer, SHALL immediately set:
- state IDLE
- o_Wr_En=0, o_Ack=0, o_Data_Out=8'h00, o_Grant_Id=0
- o_Busy=0, o_Timeout_Err=0
- counter 0, last_grant NUM_REQ-1
- synchronizer flops 1
REQ-029 Deassertion SHALL be synchronized to i_Clk_12MHz (async assert, sync release).

Structure
REQ-030 Shared package: FSM state encoding, 8-bit byte width constant, default TIMEOUT.
REQ-031 Round-robin selection SHALL live in one sub-module, rr_arbiter (request vector + last grant in; one-hot grant + index out); it is purely combinational.

Verification
REQ-032 Single request: req[2]=1, data 8'hA5, model transmitter → o_Ack[2] pulses once; o_Wr_En high until ready falls; o_Data_Out=8'hA5; transmitter serializes 0xA5.
REQ-033 Fairness: all four requests held high, data 8'h10..8'h13 → grant order 0,1,2,3,0 across five bytes.
REQ-034 Timeout: ready held 1, TIMEOUT=16, req[0]=1 → o_Wr_En high 16 cycles, then o_Timeout_Err=1, state IDLE.
REQ-035 Reset mid-transfer: assert i_Reset_N low during WAIT_DONE → all outputs at reset values in the same cycle; after release, req[1] is granted normally.
REQ-036 Ready low at grant time: ready=0, req[3]=1 → no ack until ready=1, then grant 3.
REQ-037 Drop before grant: req[1] pulses high for 1 cycle while busy → no o_Ack[1] ever.
